// File: rtl/qlearn_pkg.sv
// Shared definitions for the maze Q-learning datapath: widths, action codes,
// action-to-slot mapping and the Q-table updater FSM states.
package qlearn_pkg;

  localparam int unsigned Q_W     = 16;
  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] ACT_UP    = 4'd1;
  localparam logic [3:0] ACT_DOWN  = 4'd2;
  localparam logic [3:0] ACT_LEFT  = 4'd3;
  localparam logic [3:0] ACT_RIGHT = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_CUR = 3'd1,
    S_RD_NXT = 3'd2,
    S_MAX    = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } qupd_state_e;

  // Slot number inside a row (0 = bits [Q_W-1:0]); unknown codes fall back to ACT_UP.
  function automatic logic [1:0] slot_idx(input logic [3:0] act);
    case (act)
      ACT_RIGHT: slot_idx = 2'd0;
      ACT_LEFT:  slot_idx = 2'd1;
      ACT_DOWN:  slot_idx = 2'd2;
      ACT_UP:    slot_idx = 2'd3;
      default:   slot_idx = 2'd3;
    endcase
  endfunction

  // Bit offset of the slot selected by an action.
  function automatic int unsigned slot_lsb(input logic [3:0] act);
    slot_lsb = 32'(slot_idx(act)) * Q_W;
  endfunction

endpackage

// File: rtl/q_row_max.sv
// Combinational signed maximum over the four Q_W-bit slots of a Q-table row.
module q_row_max #(
  parameter int unsigned Q_W = 16
) (
  input  logic [4*Q_W-1:0]      i_row,
  output logic signed [Q_W-1:0] o_max_c
);

  logic signed [Q_W-1:0] w_s0, w_s1, w_s2, w_s3;
  logic signed [Q_W-1:0] w_lo, w_hi;

  // Pairwise tree reduction of the four slots.
  always_comb begin
    w_s0    = i_row[0*Q_W +: Q_W];
    w_s1    = i_row[1*Q_W +: Q_W];
    w_s2    = i_row[2*Q_W +: Q_W];
    w_s3    = i_row[3*Q_W +: Q_W];
    w_lo    = (w_s0 > w_s1) ? w_s0 : w_s1;
    w_hi    = (w_s2 > w_s3) ? w_s2 : w_s3;
    o_max_c = (w_lo > w_hi) ? w_lo : w_hi;
  end

endmodule

// File: rtl/q_table_updater.sv
// One Bellman update of Q(s,a) against the Q-table RAM:
//   Q(s,a) <- Q(s,a) + alpha*(r + gamma*maxQ(s') - Q(s,a))
// Fixed five-cycle update: read row s, read row s', compute, write row s, done.
// The max of row s' and q_old are formed in MAX and land directly in the
// registered write row, so wr_data is stable for the whole WRITE cycle.
// Optional build macro QUPD_SAT_EN: saturate q_new instead of wrapping.
module q_table_updater
  import qlearn_pkg::*;
#(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STATE_W-1:0]   state,
  input  logic [STATE_W-1:0]   next_state,
  input  logic [3:0]           action,
  input  logic [Q_W-1:0]       reward,
  input  logic                 terminal,
  output logic [STATE_W-1:0]   rd_addr,
  input  logic [4*Q_W-1:0]     rd_data,
  output logic                 wr_en,
  output logic [STATE_W-1:0]   wr_addr,
  output logic [4*Q_W-1:0]     wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IW    = Q_W + 2;
  localparam int unsigned ROW_W = 4 * Q_W;
`ifdef QUPD_SAT_EN
  localparam logic signed [IW-1:0] Q_MAX = {3'b000, {(Q_W-1){1'b1}}};
  localparam logic signed [IW-1:0] Q_MIN = {3'b111, {(Q_W-1){1'b0}}};
`endif

  qupd_state_e           r_fsm, w_fsm_nxt;
  logic [STATE_W-1:0]    r_state, r_next_state;
  logic [3:0]            r_action;
  logic signed [Q_W-1:0] r_reward;
  logic                  r_terminal;
  logic [ROW_W-1:0]      r_cur_row;

  logic signed [Q_W-1:0] w_row_max;
  logic signed [Q_W-1:0] w_old_slot;
  logic [1:0]            w_slot;
  logic signed [IW-1:0]  w_max_next, w_g, w_target, w_delta, w_q_old, w_q_new;
  logic [Q_W-1:0]        w_q_new_red;
  logic [ROW_W-1:0]      w_new_row;

  q_row_max #(.Q_W(Q_W)) u_row_max (
    .i_row   (rd_data),
    .o_max_c (w_row_max)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Next-state logic; only IDLE waits on start.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:   if (start) w_fsm_nxt = S_RD_CUR;
      S_RD_CUR: w_fsm_nxt = S_RD_NXT;
      S_RD_NXT: w_fsm_nxt = S_MAX;
      S_MAX:    w_fsm_nxt = S_WRITE;
      S_WRITE:  w_fsm_nxt = S_DONE;
      S_DONE:   w_fsm_nxt = S_IDLE;
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  // Bellman arithmetic in IW-bit signed, then reduce and splice into the row.
  always_comb begin
    w_slot     = slot_idx(r_action);
    w_old_slot = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_slot == 2'(k)) w_old_slot = r_cur_row[k*Q_W +: Q_W];
    end
    w_q_old    = IW'(w_old_slot);
    w_max_next = r_terminal ? '0 : IW'(w_row_max);
    w_g        = w_max_next - (w_max_next >>> GAMMA_SHIFT);
    w_target   = IW'(r_reward) + w_g;
    w_delta    = w_target - w_q_old;
    w_q_new    = w_q_old + (w_delta >>> ALPHA_SHIFT);
`ifdef QUPD_SAT_EN
    if (w_q_new > Q_MAX)      w_q_new_red = Q_W'(Q_MAX);
    else if (w_q_new < Q_MIN) w_q_new_red = Q_W'(Q_MIN);
    else                      w_q_new_red = Q_W'(w_q_new);
`else
    w_q_new_red = Q_W'(w_q_new);
`endif
    w_new_row = r_cur_row;
    for (int k = 0; k < 4; k++) begin
      if (w_slot == 2'(k)) w_new_row[k*Q_W +: Q_W] = w_q_new_red;
    end
  end

  // Registered outputs, request latches and row capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr      <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r_state      <= '0;
      r_next_state <= '0;
      r_action     <= '0;
      r_reward     <= '0;
      r_terminal   <= 1'b0;
      r_cur_row    <= '0;
    end else begin
      busy  <= (w_fsm_nxt != S_IDLE);
      wr_en <= (w_fsm_nxt == S_WRITE);
      done  <= (w_fsm_nxt == S_DONE);
      case (r_fsm)
        S_IDLE: begin
          if (start) begin
            r_state      <= state;
            r_next_state <= next_state;
            r_action     <= action;
            r_reward     <= reward;
            r_terminal   <= terminal;
            rd_addr      <= state;
          end
        end
        S_RD_CUR: rd_addr   <= r_next_state;
        S_RD_NXT: r_cur_row <= rd_data;
        S_MAX: begin
          wr_addr <= r_state;
          wr_data <= w_new_row;
        end
        default: ;
      endcase
    end
  end

endmodule
